prewish_pattern_sequencer: RTL and testbench



---
 rtl/prewish_pattern_sequencer_if.sv | 11 +
 rtl/prewish_pattern_sequencer.sv | 160 ++++++++++++++++
 tb/tb_prewish_pattern_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/prewish_pattern_sequencer_if.sv
// Pattern transfer channel: the sequencer drives STB_O/DAT_O, the mentor answers with ACK_I.
interface prewish_pattern_sequencer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  STB_O;
    logic [DATA_WIDTH-1:0] DAT_O;
    logic                  ACK_I;

    modport master (output STB_O, output DAT_O, input ACK_I);
    modport slave  (input STB_O, input DAT_O, output ACK_I);
endinterface

// File: rtl/prewish_pattern_sequencer.sv
// Issues patterns from a writable table as STB_O/DAT_O transfers, acknowledged by ACK_I.
// Advance source: interval (auto/resend), manual step edge, or hold; ACK timeout sets a sticky error.
module prewish_pattern_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_PATTERNS = 8,
    parameter int INTERVAL     = 2**27,
    parameter int ACK_TIMEOUT  = 16,
    parameter int ALIVE_BITS   = 23,
    localparam int IW          = $clog2(NUM_PATTERNS)
) (
    input  logic                    CLK_I,
    input  logic                    RST_I,
    input  logic [1:0]              i_mode,
    input  logic                    i_step,
    input  logic                    i_wr_en,
    input  logic [IW-1:0]           i_wr_idx,
    input  logic [DATA_WIDTH-1:0]   i_wr_dat,
    prewish_pattern_sequencer_if.master bus,
    output logic [IW-1:0]           o_index,
    output logic                    o_err,
    output logic                    o_alive,
    output logic [1:0]              o_dbg_state
);
    localparam int CNT_W = $clog2(INTERVAL);
    localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int IW1   = IW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_ADV  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_table [NUM_PATTERNS];
    logic [DATA_WIDTH-1:0] r_dat;
    logic                  r_stb;
    logic [IW-1:0]         r_index;
    logic                  r_err;
    logic [CNT_W-1:0]      r_cnt;
    logic [TO_W-1:0]       r_to_cnt;
    logic [1:0]            r_mode_prev;
    logic                  r_step_prev;
    logic                  r_step_arm;
    logic [ALIVE_BITS-1:0] r_alive;

    logic w_interval_mode;
    logic w_mode_enter;
    logic w_trigger;
    logic w_launch;
    logic w_ack_done;
    logic w_timeout;
    logic w_adv;
    logic w_idx_ok;

    function automatic logic [DATA_WIDTH-1:0] default_entry(input int k);
        default_entry = '0;
        default_entry[DATA_WIDTH-1-(k % DATA_WIDTH)] = 1'b1;
    endfunction

    // Out-of-range write indices only exist when the depth is not a power of two.
    if (NUM_PATTERNS == (1 << IW)) begin : g_idx_full
        assign w_idx_ok = 1'b1;
    end else begin : g_idx_part
        assign w_idx_ok = ({1'b0, i_wr_idx} < IW1'(NUM_PATTERNS));
    end

    assign w_interval_mode = (i_mode == 2'b00) || (i_mode == 2'b11);
    assign w_mode_enter    = w_interval_mode && (i_mode != r_mode_prev);
    assign w_trigger = (w_interval_mode && !w_mode_enter && (r_cnt == CNT_W'(INTERVAL - 1)))
                     || ((i_mode == 2'b01) && i_step && !r_step_prev && r_step_arm);

    always_ff @(posedge CLK_I) begin
        if (RST_I) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_launch   = 1'b0;
        w_ack_done = 1'b0;
        w_timeout  = 1'b0;
        w_adv      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_trigger) begin
                    w_launch = 1'b1;
                    w_next   = S_SEND;
                end
            end
            S_SEND: begin
                // ACK on the expiry cycle wins over the timeout.
                if (bus.ACK_I) begin
                    w_ack_done = 1'b1;
                    w_next     = S_ADV;
                end else if (r_to_cnt == TO_W'(ACK_TIMEOUT)) begin
                    w_timeout = 1'b1;
                    w_next    = S_ADV;
                end
            end
            S_ADV: begin
                w_adv  = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        // Mode history tracks through reset so releasing reset is never a mode change.
        r_mode_prev <= i_mode;
        if (RST_I) begin
            for (int k = 0; k < NUM_PATTERNS; k++) r_table[k] <= default_entry(k);
            r_dat       <= '0;
            r_stb       <= 1'b0;
            r_index     <= '0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_to_cnt    <= '0;
            r_step_prev <= 1'b0;
            r_step_arm  <= 1'b0;
            r_alive     <= '0;
        end else begin
            r_alive     <= r_alive + ALIVE_BITS'(1);
            r_step_prev <= i_step;
            r_step_arm  <= 1'b1;
            if (i_wr_en && w_idx_ok) r_table[i_wr_idx] <= i_wr_dat;

            if (w_mode_enter) begin
                r_cnt <= '0;
            end else if (w_interval_mode) begin
                r_cnt <= (r_cnt == CNT_W'(INTERVAL - 1)) ? '0 : r_cnt + CNT_W'(1);
            end

            if (w_launch) begin
                r_dat    <= r_table[r_index];
                r_stb    <= 1'b1;
                r_to_cnt <= TO_W'(1);
            end else if (w_ack_done || w_timeout) begin
                r_stb <= 1'b0;
            end else if (r_state == S_SEND) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end

            if (w_timeout) r_err <= 1'b1;

            if (w_adv && (i_mode != 2'b11)) begin
                r_index <= (r_index == IW'(NUM_PATTERNS - 1)) ? '0 : r_index + IW'(1);
            end
        end
    end

    assign bus.STB_O   = r_stb;
    assign bus.DAT_O   = r_dat;
    assign o_index     = r_index;
    assign o_err       = r_err;
    assign o_alive     = r_alive[ALIVE_BITS-1];
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_prewish_pattern_sequencer.sv
// Directed bench for prewish_pattern_sequencer: vector tables for the main modes plus
// hand-written sequences for hold, mode re-entry and out-of-range table writes.
module tb_prewish_pattern_sequencer;
    typedef struct {
        int         cyc;
        logic       rst;
        logic [1:0] mode;
        logic       step;
        logic       ack;
        logic       wr_en;
        logic [1:0] wr_idx;
        logic [7:0] wr_dat;
        logic       e_stb;
        logic [7:0] e_dat;
        logic [1:0] e_idx;
        logic       e_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       step;
    logic       wr_en;
    logic [1:0] wr_idx;
    logic [7:0] wr_dat;
    logic [1:0] idx1;
    logic       err1;
    logic       alive1;
    logic [1:0] state1;

    logic       wr2_en;
    logic [2:0] wr2_idx;
    logic [7:0] wr2_dat;
    logic [2:0] idx2;
    logic       err2;
    logic       alive2;
    logic [1:0] state2;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         quiet_hits;
    logic [3:0] alive_cnt = 4'd0;
    vec_t       vecs[$];
    logic [7:0] exp_q[$];

    prewish_pattern_sequencer_if #(.DATA_WIDTH(8)) bus1 ();
    prewish_pattern_sequencer_if #(.DATA_WIDTH(8)) bus2 ();

    prewish_pattern_sequencer #(
        .DATA_WIDTH(8), .NUM_PATTERNS(4), .INTERVAL(10), .ACK_TIMEOUT(4), .ALIVE_BITS(4)
    ) u_dut (
        .CLK_I(clk), .RST_I(rst), .i_mode(mode), .i_step(step),
        .i_wr_en(wr_en), .i_wr_idx(wr_idx), .i_wr_dat(wr_dat),
        .bus(bus1), .o_index(idx1), .o_err(err1), .o_alive(alive1), .o_dbg_state(state1)
    );

    // Five-entry table, so index values 5..7 are representable but out of range.
    prewish_pattern_sequencer #(
        .DATA_WIDTH(8), .NUM_PATTERNS(5), .INTERVAL(10), .ACK_TIMEOUT(4), .ALIVE_BITS(4)
    ) u_dut5 (
        .CLK_I(clk), .RST_I(rst), .i_mode(mode), .i_step(step),
        .i_wr_en(wr2_en), .i_wr_idx(wr2_idx), .i_wr_dat(wr2_dat),
        .bus(bus2), .o_index(idx2), .o_err(err2), .o_alive(alive2), .o_dbg_state(state2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        logic rst_now;
        rst_now = rst;
        @(posedge clk);
        #1;
        alive_cnt = rst_now ? 4'd0 : alive_cnt + 4'd1;
        cyc++;
    endtask

    task automatic do_reset(input logic [1:0] m, input logic s);
        rst = 1'b1;
        mode = m;
        step = s;
        bus1.ACK_I = 1'b0;
        bus2.ACK_I = 1'b1;
        wr_en = 1'b0; wr_idx = '0; wr_dat = '0;
        wr2_en = 1'b0; wr2_idx = '0; wr2_dat = '0;
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic add(input int c, input logic r, input logic [1:0] m, input logic s,
                       input logic a, input logic we, input logic [1:0] wi, input logic [7:0] wd,
                       input logic es, input logic [7:0] ed, input logic [1:0] ei, input logic ee);
        vec_t v;
        v.cyc = c; v.rst = r; v.mode = m; v.step = s; v.ack = a;
        v.wr_en = we; v.wr_idx = wi; v.wr_dat = wd;
        v.e_stb = es; v.e_dat = ed; v.e_idx = ei; v.e_err = ee;
        vecs.push_back(v);
    endtask

    // At each vector's cycle: compare outputs, then drive that vector's inputs.
    task automatic run_vectors(input string tag);
        foreach (vecs[i]) begin
            if (vecs[i].cyc < cyc) check({tag, "_order"}, cyc, vecs[i].cyc);
            while (cyc < vecs[i].cyc) tick();
            check({tag, "_stb"},   int'(bus1.STB_O), int'(vecs[i].e_stb));
            check({tag, "_dat"},   int'(bus1.DAT_O), int'(vecs[i].e_dat));
            check({tag, "_idx"},   int'(idx1),       int'(vecs[i].e_idx));
            check({tag, "_err"},   int'(err1),       int'(vecs[i].e_err));
            check({tag, "_alive"}, int'(alive1),     int'(alive_cnt[3]));
            rst        = vecs[i].rst;
            mode       = vecs[i].mode;
            step       = vecs[i].step;
            bus1.ACK_I = vecs[i].ack;
            wr_en      = vecs[i].wr_en;
            wr_idx     = vecs[i].wr_idx;
            wr_dat     = vecs[i].wr_dat;
        end
        vecs.delete();
    endtask

    initial begin
        // Auto mode, ACK tied high, entry 1 rewritten to A5 before the first trigger.
        do_reset(2'b00, 1'b0);
        check("rst_state", int'(state1), 0);
        check("rst_err5", int'(err2), 0);
        add( 0, 0, 2'b00, 0, 1, 1, 2'd1, 8'hA5,  0, 8'h00, 2'd0, 0);
        add( 9, 0, 2'b00, 0, 1, 0, 2'd0, 8'h00,  0, 8'h00, 2'd0, 0);
        add(10, 0, 2'b00, 0, 1, 0, 2'd0, 8'h00,  1, 8'h80, 2'd0, 0);
        add(11, 0, 2'b00, 0, 1, 0, 2'd0, 8'h00,  0, 8'h80, 2'd0, 0);
        add(12, 0, 2'b00, 0, 1, 0, 2'd0, 8'h00,  0, 8'h80, 2'd1, 0);
        add(20, 0, 2'b00, 0, 1, 0, 2'd0, 8'h00,  1, 8'hA5, 2'd1, 0);
        add(22, 0, 2'b00, 0, 1, 0, 2'd0, 8'h00,  0, 8'hA5, 2'd2, 0);
        add(30, 0, 2'b00, 0, 1, 0, 2'd0, 8'h00,  1, 8'h20, 2'd2, 0);
        add(40, 0, 2'b00, 0, 1, 0, 2'd0, 8'h00,  1, 8'h10, 2'd3, 0);
        add(41, 0, 2'b00, 0, 1, 0, 2'd0, 8'h00,  0, 8'h10, 2'd3, 0);
        add(42, 0, 2'b00, 0, 1, 0, 2'd0, 8'h00,  0, 8'h10, 2'd0, 0);
        add(50, 0, 2'b00, 0, 1, 0, 2'd0, 8'h00,  1, 8'h80, 2'd0, 0);
        run_vectors("auto");

        // ACK on expiry cycle, ACK during IDLE, then a genuine timeout.
        do_reset(2'b00, 1'b0);
        add( 0, 0, 2'b00, 0, 0, 0, 2'd0, 8'h00,  0, 8'h00, 2'd0, 0);
        add( 9, 0, 2'b00, 0, 0, 0, 2'd0, 8'h00,  0, 8'h00, 2'd0, 0);
        add(10, 0, 2'b00, 0, 0, 0, 2'd0, 8'h00,  1, 8'h80, 2'd0, 0);
        add(13, 0, 2'b00, 0, 1, 0, 2'd0, 8'h00,  1, 8'h80, 2'd0, 0);
        add(14, 0, 2'b00, 0, 1, 0, 2'd0, 8'h00,  0, 8'h80, 2'd0, 0);
        add(15, 0, 2'b00, 0, 1, 0, 2'd0, 8'h00,  0, 8'h80, 2'd1, 0);
        add(19, 0, 2'b00, 0, 0, 0, 2'd0, 8'h00,  0, 8'h80, 2'd1, 0);
        add(20, 0, 2'b00, 0, 0, 0, 2'd0, 8'h00,  1, 8'h40, 2'd1, 0);
        add(23, 0, 2'b00, 0, 0, 0, 2'd0, 8'h00,  1, 8'h40, 2'd1, 0);
        add(24, 0, 2'b00, 0, 0, 0, 2'd0, 8'h00,  0, 8'h40, 2'd1, 1);
        add(25, 0, 2'b00, 0, 1, 0, 2'd0, 8'h00,  0, 8'h40, 2'd2, 1);
        add(30, 0, 2'b00, 0, 1, 0, 2'd0, 8'h00,  1, 8'h20, 2'd2, 1);
        add(31, 0, 2'b00, 0, 1, 0, 2'd0, 8'h00,  0, 8'h20, 2'd2, 1);
        add(40, 0, 2'b00, 0, 1, 0, 2'd0, 8'h00,  1, 8'h10, 2'd3, 1);
        run_vectors("tmo");

        // Manual step, with i_step held high through reset release.
        do_reset(2'b01, 1'b1);
        add( 0, 0, 2'b01, 1, 1, 0, 2'd0, 8'h00,  0, 8'h00, 2'd0, 0);
        add( 3, 0, 2'b01, 0, 1, 0, 2'd0, 8'h00,  0, 8'h00, 2'd0, 0);
        add( 5, 0, 2'b01, 1, 1, 0, 2'd0, 8'h00,  0, 8'h00, 2'd0, 0);
        add( 6, 0, 2'b01, 1, 1, 0, 2'd0, 8'h00,  1, 8'h80, 2'd0, 0);
        add( 7, 0, 2'b01, 0, 1, 0, 2'd0, 8'h00,  0, 8'h80, 2'd0, 0);
        add( 8, 0, 2'b01, 0, 1, 0, 2'd0, 8'h00,  0, 8'h80, 2'd1, 0);
        add(12, 0, 2'b01, 0, 1, 0, 2'd0, 8'h00,  0, 8'h80, 2'd1, 0);
        add(20, 0, 2'b01, 1, 1, 0, 2'd0, 8'h00,  0, 8'h80, 2'd1, 0);
        add(21, 0, 2'b01, 0, 1, 0, 2'd0, 8'h00,  1, 8'h40, 2'd1, 0);
        add(22, 0, 2'b01, 0, 1, 0, 2'd0, 8'h00,  0, 8'h40, 2'd1, 0);
        add(23, 0, 2'b01, 0, 1, 0, 2'd0, 8'h00,  0, 8'h40, 2'd2, 0);
        add(30, 0, 2'b01, 0, 1, 0, 2'd0, 8'h00,  0, 8'h40, 2'd2, 0);
        run_vectors("step");

        // Resend, then hold entered mid-transfer, then back to auto.
        do_reset(2'b11, 1'b0);
        add( 0, 0, 2'b11, 0, 1, 0, 2'd0, 8'h00,  0, 8'h00, 2'd0, 0);
        add(10, 0, 2'b11, 0, 1, 0, 2'd0, 8'h00,  1, 8'h80, 2'd0, 0);
        add(12, 0, 2'b11, 0, 1, 0, 2'd0, 8'h00,  0, 8'h80, 2'd0, 0);
        add(20, 0, 2'b11, 0, 1, 0, 2'd0, 8'h00,  1, 8'h80, 2'd0, 0);
        add(30, 0, 2'b10, 0, 1, 0, 2'd0, 8'h00,  1, 8'h80, 2'd0, 0);
        add(32, 0, 2'b10, 0, 1, 0, 2'd0, 8'h00,  0, 8'h80, 2'd1, 0);
        run_vectors("resend");
        quiet_hits = 0;
        repeat (100) begin
            tick();
            if (bus1.STB_O) quiet_hits++;
        end
        check("hold_quiet", quiet_hits, 0);
        add(132, 0, 2'b00, 0, 1, 0, 2'd0, 8'h00, 0, 8'h80, 2'd1, 0);
        add(142, 0, 2'b00, 0, 1, 0, 2'd0, 8'h00, 0, 8'h80, 2'd1, 0);
        add(143, 0, 2'b00, 0, 1, 0, 2'd0, 8'h00, 1, 8'h40, 2'd1, 0);
        run_vectors("reenter");

        // Reset in the first STB cycle clears err, index and the rewritten table entry.
        do_reset(2'b00, 1'b0);
        add( 0, 0, 2'b00, 0, 0, 1, 2'd0, 8'hA5,  0, 8'h00, 2'd0, 0);
        add( 9, 0, 2'b00, 0, 0, 0, 2'd0, 8'h00,  0, 8'h00, 2'd0, 0);
        add(10, 0, 2'b00, 0, 0, 0, 2'd0, 8'h00,  1, 8'hA5, 2'd0, 0);
        add(14, 0, 2'b00, 0, 0, 0, 2'd0, 8'h00,  0, 8'hA5, 2'd0, 1);
        add(15, 0, 2'b00, 0, 0, 0, 2'd0, 8'h00,  0, 8'hA5, 2'd1, 1);
        add(20, 1, 2'b00, 0, 0, 0, 2'd0, 8'h00,  1, 8'h40, 2'd1, 1);
        add(21, 0, 2'b00, 0, 1, 0, 2'd0, 8'h00,  0, 8'h00, 2'd0, 0);
        add(30, 0, 2'b00, 0, 1, 0, 2'd0, 8'h00,  0, 8'h00, 2'd0, 0);
        add(31, 0, 2'b00, 0, 1, 0, 2'd0, 8'h00,  1, 8'h80, 2'd0, 0);
        run_vectors("midrst");

        // Five-entry table: writes to indices 7, 5 and 6 must leave the defaults intact.
        do_reset(2'b00, 1'b0);
        wr2_en = 1'b1; wr2_dat = 8'h3C; wr2_idx = 3'd7;
        tick();
        wr2_idx = 3'd5;
        tick();
        wr2_idx = 3'd6;
        tick();
        wr2_en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            logic [7:0] e;
            e = 8'h80 >> (k % 5);
            exp_q.push_back(e);
        end
        for (int k = 0; k < 6; k++) begin
            logic [7:0] e;
            while (cyc < 10 + 10 * k) tick();
            e = exp_q.pop_front();
            check("p5_stb", int'(bus2.STB_O), 1);
            check("p5_idx", int'(idx2), k % 5);
            check("p5_dat", int'(bus2.DAT_O), int'(e));
        end
        check("p5_err", int'(err2), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
